// File: rtl/fixed_packer.sv
// Signed fixed-point (1 sign, 1 int, WIDTH frac) to IEEE-754 single converter, Nios II multi-cycle CI.
// Optional macro FIXED_PACKER_FAST_NORM_EN adds a 4-bit normalisation skip when the top nibble is zero.
module fixed_packer #(
   parameter int WIDTH = 22
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clk_en,
   input  logic        start,
   input  logic [31:0] dataa,
   output logic        done,
   output logic [31:0] result
);

   localparam int N   = WIDTH + 2;
   localparam int SW  = 5;
   localparam int PAD = 24 - N;

   typedef enum logic [1:0] {IDLE, NORM, PACK} state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   mag_q, mag_d;
   logic [SW-1:0]  s_q, s_d;
   logic           sign_q, sign_d;
   logic           zero_q, zero_d;
   logic           done_q, done_d;
   logic [31:0]    result_q, result_d;

   logic [N-1:0]   din;
   logic [22:0]    mant;
   logic [7:0]     exp_b;
   logic           unused_hi;

   assign din       = dataa[N-1:0];
   assign unused_hi = ^dataa[31:N];

   always_comb begin
      state_d  = state_q;
      mag_d    = mag_q;
      s_d      = s_q;
      sign_d   = sign_q;
      zero_d   = zero_q;
      done_d   = 1'b0;
      result_d = result_q;
      // mag below the leading one, left-aligned into the 23-bit fraction
      mant     = 23'(mag_q[N-2:0]) << PAD;
      exp_b    = 8'd128 - {3'b000, s_q};
      case (state_q)
         IDLE: begin
            if (start) begin
               sign_d  = din[N-1];
               mag_d   = din[N-1] ? -din : din;
               s_d     = '0;
               zero_d  = (din == '0);
               state_d = NORM;
            end
         end
         NORM: begin
            if (zero_q || mag_q[N-1]) begin
               state_d = PACK;
            end else begin
`ifdef FIXED_PACKER_FAST_NORM_EN
               if (mag_q[N-1:N-4] == 4'd0) begin
                  mag_d = mag_q << 4;
                  s_d   = s_q + SW'(4);
               end else begin
                  mag_d = mag_q << 1;
                  s_d   = s_q + SW'(1);
               end
`else
               mag_d = mag_q << 1;
               s_d   = s_q + SW'(1);
`endif
            end
         end
         PACK: begin
            result_d = zero_q ? 32'h0 : {sign_q, exp_b, mant};
            done_d   = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // clk_en low freezes everything, including a pending done pulse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         mag_q    <= '0;
         s_q      <= '0;
         sign_q   <= 1'b0;
         zero_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= 32'h0;
      end else if (clk_en) begin
         state_q  <= state_d;
         mag_q    <= mag_d;
         s_q      <= s_d;
         sign_q   <= sign_d;
         zero_q   <= zero_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   assign done   = done_q;
   assign result = result_q;

endmodule

// File: doc/fixed_packer.md
Name: fixed_packer

Overview:
- Multi-cycle Nios II custom-instruction block that converts a signed fixed-point CORDIC result back into IEEE-754 single precision.
- It is the inverse of the float-to-fixed unpacking stage: CORDIC output in, float32 out to the CPU.
- Input format is two's complement, N = WIDTH+2 bits: 1 sign bit, 1 integer bit, WIDTH fraction bits. Range is [-2, 2).
- Normalisation is iterative, using a leading-zero shift loop under a start/done handshake.

Parameters:
- WIDTH, 22, number of fraction bits. Legal range 8..22. N = WIDTH+2 ≤ 24, so every conversion is exact (no rounding).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- clk_en  input  1  Nios clock enable; when low, all state holds.
- start  input  1  one-cycle request; sampled only in IDLE with clk_en=1.
- dataa  input  32  operand; only dataa[N-1:0] is used, upper bits are ignored.
- done  output  1  one-cycle pulse; result is valid.
- result  output  32  float32; held stable until the next accepted start.

Behaviour:
- Reset (async assert, sync release): state=IDLE, done=0, result=32'h0, internal mag/shift count/sign cleared.
- States: IDLE, NORM, PACK.
- IDLE:
  - On start & clk_en: sign <= dataa[N-1].
  - mag <= |dataa[N-1:0]| as N-bit unsigned. -2^(N-1) maps to 2^(N-1), which fits.
  - s <= 0, zero flag <= (dataa[N-1:0]==0), go to NORM.
- NORM:
  - If zero flag is set, or mag[N-1]==1: go to PACK.
  - Else mag <= mag<<1, s <= s+1, stay in NORM.
- PACK:
  - zero: result <= 32'h00000000. Never -0.
  - nonzero: result <= {sign, 8'd(128-s), mantissa}.
  - mantissa = mag[N-2:0] left-aligned into 23 bits, zero-padded on the LSB side.
  - done <= 1 for exactly one cycle, then back to IDLE.
- Value relation: fixed value = signed(data)/2^WIDTH. A leading one at bit N-1-s gives exponent 2^(1-s). Biased exponent range is 128 down to 128-(N-1).
- Latency, measured from the start-sampling edge to the edge where done rises: 2 + shift steps.
  - Zero input: shift steps = 0.
  - Nonzero input: shift steps = s.
  - Worst case (WIDTH=22, input 1 LSB): 25 cycles.
- clk_en=0 in any state: freeze state, mag and s. If done is high it stays high until the next enabled edge, so it is still seen as a single enabled-cycle pulse.
- start while in NORM or PACK: ignored, no queuing.
- start coincident with done (PACK→IDLE edge): not accepted; must be reissued in IDLE.
- reset_n low mid-operation: immediate return to IDLE, done=0, result=0; the operation is lost.

Optional Feature:
- Macro: FIXED_PACKER_FAST_NORM_EN.
- Defined: in NORM, if mag[N-1:N-4]==0, then mag <= mag<<4 and s <= s+4. Otherwise the step is the normal 1-bit shift.
  - Shift steps = floor(lz/4) + (lz mod 4), where lz = leading zeros.
  - Results are bit-identical to the disabled build.
  - Worst case with WIDTH=22: 10 cycles.
- Undefined: 1-bit shift only; latency exactly as in Behaviour.

Test Plan (WIDTH=22 unless stated):
- 1.0 and -1.0: dataa=0x400000 → result=0x3f800000, done at cycle 3; dataa=0xC00000 → 0xbf800000.
- 0.5 and 0.75: 0x200000 → 0x3f000000; 0x300000 → 0x3f400000; both with done at cycle 4.
- Extremes:
  - 0x000001 → 0x34800000, done at cycle 25 (cycle 10 with FIXED_PACKER_FAST_NORM_EN).
  - 0x800000 (-2.0) → 0xc0000000 at cycle 2.
  - 0x000000 → 0x00000000 at cycle 2.
- Handshake: start pulsed again during NORM is ignored, and result stays stable after done. clk_en held low for 5 cycles mid-NORM stretches latency by exactly 5 with an unchanged result.
- Reset mid-NORM: reset_n pulsed low at cycle 10 of 0x000001 → done=0 and result=0 immediately. A subsequent start with 0x400000 → 0x3f800000.
- Round-trip sweep: 10k random 24-bit inputs, each output checked against the reference model signed(x)/2^22 converted to float32 (exact); done pulse width checked to be 1.
